// File: rtl/target_overlay_pkg.sv
// Shared types and constants for the target overlay: lock states, pipeline
// depth, default ring colours and crosshair reach.
package target_overlay_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    LOST   = 2'd2
  } lock_state_t;

  localparam int          PIPE_LAT       = 3;
  localparam logic [11:0] LOCK_COLOR_DEF = 12'h0F0;
  localparam logic [11:0] LOST_COLOR_DEF = 12'hF00;
  localparam int          CROSSHAIR_HALF = 8;

endpackage

// File: rtl/target_overlay_if.sv
// Video timing, tracker result and overlay output bundle between the pixel
// pipeline and the target overlay.
interface target_overlay_if;
  logic        vsync;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [11:0] pixel_in;
  logic [31:0] x_center;
  logic [31:0] y_center;
  logic [23:0] radius;
  logic [11:0] pixel_out;
  logic        target_valid;
  logic [1:0]  lock_state;

  modport master (
    output vsync, hcount, vcount, pixel_in, x_center, y_center, radius,
    input  pixel_out, target_valid, lock_state
  );

  modport slave (
    input  vsync, hcount, vcount, pixel_in, x_center, y_center, radius,
    output pixel_out, target_valid, lock_state
  );
endinterface

// File: rtl/target_lock_fsm.sv
// Frame-rate lock qualifier: SEARCH -> LOCKED after enough present frames,
// LOCKED -> LOST on a miss, LOST -> SEARCH after a run of misses.
module target_lock_fsm
  import target_overlay_pkg::*;
#(
  parameter int LOCK_FRAMES = 3,
  parameter int LOST_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        frame_strobe,
  input  logic        present,
  output lock_state_t state,
  output logic        latch_enable
);

  localparam int LOCK_W = $clog2(LOCK_FRAMES + 1);
  localparam int LOST_W = $clog2(LOST_FRAMES + 1);

  lock_state_t       state_reg, state_next;
  logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic [LOST_W-1:0] lost_cnt_reg, lost_cnt_next;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_reg    <= SEARCH;
      lock_cnt_reg <= '0;
      lost_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
      lost_cnt_reg <= lost_cnt_next;
    end
  end

  // The position latch is frozen whenever the current frame is a miss outside SEARCH
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    lost_cnt_next = lost_cnt_reg;
    latch_enable  = 1'b0;
    if (frame_strobe) begin
      case (state_reg)
        SEARCH: begin
          latch_enable = 1'b1;
          if (!present) begin
            lock_cnt_next = '0;
          end else if (lock_cnt_reg == LOCK_W'(LOCK_FRAMES - 1)) begin
            state_next    = LOCKED;
            lock_cnt_next = '0;
          end else begin
            lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
          end
        end
        LOCKED: begin
          if (present) begin
            latch_enable = 1'b1;
          end else begin
            state_next    = LOST;
            lost_cnt_next = '0;
          end
        end
        LOST: begin
          if (present) begin
            latch_enable  = 1'b1;
            state_next    = LOCKED;
            lost_cnt_next = '0;
          end else if (lost_cnt_reg == LOST_W'(LOST_FRAMES - 1)) begin
            state_next    = SEARCH;
            lost_cnt_next = '0;
          end else begin
            lost_cnt_next = lost_cnt_reg + LOST_W'(1);
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/target_overlay.sv
// Draws the tracked target as a ring on the VGA stream with 3-cycle latency.
// Optional crosshair: define TARGET_OVERLAY_CROSSHAIR_EN.
module target_overlay
  import target_overlay_pkg::*;
#(
  parameter int          MIN_RADIUS  = 4,
  parameter int          LOCK_FRAMES = 3,
  parameter int          LOST_FRAMES = 30,
  parameter int          RING_W      = 3,
  parameter logic [11:0] LOCK_COLOR  = LOCK_COLOR_DEF,
  parameter logic [11:0] LOST_COLOR  = LOST_COLOR_DEF
) (
  input  logic             clk,
  input  logic             rst_in,
  target_overlay_if.slave  bus
);

  logic        vsync_q_reg;
  logic        fall;
  logic [10:0] x_sat;
  logic [9:0]  y_sat, r_sat, ri_sat;
  logic [19:0] rr_next, ri2_next;
  logic        present, latch_enable;
  lock_state_t state;

  logic [10:0] xc_reg;
  logic [9:0]  yc_reg, r_reg;
  logic [19:0] rr_reg, ri2_reg;

  always_ff @(posedge clk) begin
    if (rst_in) vsync_q_reg <= 1'b0;
    else        vsync_q_reg <= bus.vsync;
  end

  assign fall = vsync_q_reg & ~bus.vsync;

  // Saturate tracker results to screen range; squares are precomputed per frame
  always_comb begin
    x_sat    = (bus.x_center > 32'd2047) ? 11'd2047 : bus.x_center[10:0];
    y_sat    = (bus.y_center > 32'd1023) ? 10'd1023 : bus.y_center[9:0];
    r_sat    = (bus.radius > 24'd1023) ? 10'd1023 : bus.radius[9:0];
    ri_sat   = (int'(r_sat) > RING_W) ? r_sat - 10'(RING_W) : 10'd0;
    rr_next  = 20'(r_sat) * 20'(r_sat);
    ri2_next = 20'(ri_sat) * 20'(ri_sat);
    present  = int'(r_sat) >= MIN_RADIUS;
  end

  target_lock_fsm #(
    .LOCK_FRAMES (LOCK_FRAMES),
    .LOST_FRAMES (LOST_FRAMES)
  ) u_fsm (
    .clk          (clk),
    .rst_in       (rst_in),
    .frame_strobe (fall),
    .present      (present),
    .state        (state),
    .latch_enable (latch_enable)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      xc_reg  <= '0;
      yc_reg  <= '0;
      r_reg   <= '0;
      rr_reg  <= '0;
      ri2_reg <= '0;
    end else if (latch_enable) begin
      xc_reg  <= x_sat;
      yc_reg  <= y_sat;
      r_reg   <= r_sat;
      rr_reg  <= rr_next;
      ri2_reg <= ri2_next;
    end
  end

  // S1: signed offsets, widened by one bit so off-screen centres never wrap
  logic signed [11:0] dx_reg, dy_reg;
  always_ff @(posedge clk) begin
    if (rst_in) begin
      dx_reg <= '0;
      dy_reg <= '0;
    end else begin
      dx_reg <= $signed({1'b0, bus.hcount}) - $signed({1'b0, xc_reg});
      dy_reg <= $signed({2'b00, bus.vcount}) - $signed({2'b00, yc_reg});
    end
  end

  // S2: squared distance from magnitudes
  logic [11:0] adx, ady;
  logic [22:0] d2_reg;
  always_comb begin
    adx = dx_reg[11] ? 12'(-dx_reg) : 12'(dx_reg);
    ady = dy_reg[11] ? 12'(-dy_reg) : 12'(dy_reg);
  end

  always_ff @(posedge clk) begin
    if (rst_in) d2_reg <= '0;
    else        d2_reg <= 23'(adx) * 23'(adx) + 23'(ady) * 23'(ady);
  end

`ifdef TARGET_OVERLAY_CROSSHAIR_EN
  logic cross_reg;
  always_ff @(posedge clk) begin
    if (rst_in) cross_reg <= 1'b0;
    else        cross_reg <= ((dx_reg == '0) && (ady <= 12'(CROSSHAIR_HALF))) ||
                             ((dy_reg == '0) && (adx <= 12'(CROSSHAIR_HALF)));
  end
`endif

  // Pixel delay line matching the first PIPE_LAT-1 stages
  logic [11:0] pix_dly_reg [PIPE_LAT-1];
  generate
    for (genvar gi = 0; gi < PIPE_LAT - 1; gi++) begin : g_pix_dly
      always_ff @(posedge clk) begin
        if (rst_in)        pix_dly_reg[gi] <= '0;
        else if (gi == 0)  pix_dly_reg[gi] <= bus.pixel_in;
        else               pix_dly_reg[gi] <= pix_dly_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  // S3: ring test and colour select
  logic        ring, paint;
  logic [11:0] pixel_out_next, pixel_out_reg;
  always_comb begin
    ring = (r_reg != '0) && (d2_reg <= 23'(rr_reg)) && (d2_reg >= 23'(ri2_reg));
`ifdef TARGET_OVERLAY_CROSSHAIR_EN
    paint = ring | cross_reg;
`else
    paint = ring;
`endif
    pixel_out_next = pix_dly_reg[PIPE_LAT-2];
    if (paint && state == LOCKED)    pixel_out_next = LOCK_COLOR;
    else if (paint && state == LOST) pixel_out_next = LOST_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst_in) pixel_out_reg <= '0;
    else        pixel_out_reg <= pixel_out_next;
  end

  assign bus.pixel_out    = pixel_out_reg;
  assign bus.target_valid = (state == LOCKED);
  assign bus.lock_state   = state;

endmodule

// File: tb/tb_target_overlay.sv
// Directed bench for target_overlay: lock qualification, ring colours,
// saturation, mid-frame stability, reset flush and optional crosshair.
module tb_target_overlay;

  logic clk;
  logic rst_in;
  int   checks;
  int   fails;

  target_overlay_if bus ();

  target_overlay dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame boundary: vsync pulse high then low, tracker values set beforehand
  task automatic frame(input int x, input int y, input int r);
    @(negedge clk);
    bus.x_center = 32'(x);
    bus.y_center = 32'(y);
    bus.radius   = 24'(r);
    bus.vsync    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.vsync = 1'b0;
    @(posedge clk);
    #1;
    $display("frame x=%0d y=%0d r=%0d -> lock_state=%0d target_valid=%0b",
             x, y, r, bus.lock_state, bus.target_valid);
  endtask

  task automatic probe(input int h, input int v, input logic [11:0] pin,
                       output logic [11:0] obs);
    @(negedge clk);
    bus.hcount   = 11'(h);
    bus.vcount   = 10'(v);
    bus.pixel_in = pin;
    repeat (3) @(posedge clk);
    #1 obs = bus.pixel_out;
    $display("pixel (%0d,%0d) in=%h out=%h", h, v, pin, obs);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    bus.pixel_in = 12'h5A5;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.pixel_out !== 12'h000) begin
      fails++; $display("FAIL reset_pixel_out: got %h expected 000", bus.pixel_out);
    end
    checks++;
    if (bus.lock_state !== 2'd0) begin
      fails++; $display("FAIL reset_lock_state: got %0d expected 0", bus.lock_state);
    end
    checks++;
    if (bus.target_valid !== 1'b0) begin
      fails++; $display("FAIL reset_target_valid: got %0b expected 0", bus.target_valid);
    end
    @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic test_search();
    logic [11:0] exp;
    for (int f = 0; f < 2; f++) begin
      frame(512, 384, 20);
      checks++;
      if (bus.lock_state !== 2'd0) begin
        fails++; $display("FAIL search_state: got %0d expected 0", bus.lock_state);
      end
      checks++;
      if (bus.target_valid !== 1'b0) begin
        fails++; $display("FAIL search_valid: got %0b expected 0", bus.target_valid);
      end
    end
    // Stream on a ring pixel: SEARCH passes pixel_in through, 3 cycles late
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.hcount   = 11'd532;
      bus.vcount   = 10'd384;
      bus.pixel_in = 12'h100 + 12'(i);
      @(posedge clk);
      #1;
      if (i >= 2) begin
        exp = 12'h100 + 12'(i - 2);
        checks++;
        if (bus.pixel_out !== exp) begin
          fails++; $display("FAIL search_latency[%0d]: got %h expected %h", i, bus.pixel_out, exp);
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [11:0] obs;
    frame(512, 384, 20);
    checks++;
    if (bus.lock_state !== 2'd1) begin
      fails++; $display("FAIL lock_state: got %0d expected 1", bus.lock_state);
    end
    checks++;
    if (bus.target_valid !== 1'b1) begin
      fails++; $display("FAIL lock_valid: got %0b expected 1", bus.target_valid);
    end
    probe(532, 384, 12'h123, obs);
    checks++;
    if (obs !== 12'h0F0) begin
      fails++; $display("FAIL lock_ring_edge: got %h expected 0F0", obs);
    end
    probe(492, 384, 12'h124, obs);
    checks++;
    if (obs !== 12'h0F0) begin
      fails++; $display("FAIL lock_ring_left: got %h expected 0F0", obs);
    end
    probe(512, 384, 12'h456, obs);
    checks++;
    if (obs !== 12'h456) begin
      fails++; $display("FAIL lock_centre: got %h expected 456", obs);
    end
    probe(528, 384, 12'h789, obs);
    checks++;
    if (obs !== 12'h789) begin
      fails++; $display("FAIL lock_inside_ri: got %h expected 789", obs);
    end
  endtask

  task automatic test_lost();
    logic [11:0] obs;
    frame(512, 384, 2);
    checks++;
    if (bus.lock_state !== 2'd2) begin
      fails++; $display("FAIL lost_state: got %0d expected 2", bus.lock_state);
    end
    checks++;
    if (bus.target_valid !== 1'b0) begin
      fails++; $display("FAIL lost_valid: got %0b expected 0", bus.target_valid);
    end
    probe(532, 384, 12'h123, obs);
    checks++;
    if (obs !== 12'hF00) begin
      fails++; $display("FAIL lost_ring_x: got %h expected F00", obs);
    end
    probe(512, 404, 12'h124, obs);
    checks++;
    if (obs !== 12'hF00) begin
      fails++; $display("FAIL lost_ring_y: got %h expected F00", obs);
    end
    frame(100, 100, 20);
    checks++;
    if (bus.lock_state !== 2'd1) begin
      fails++; $display("FAIL relock_state: got %0d expected 1", bus.lock_state);
    end
    probe(120, 100, 12'h222, obs);
    checks++;
    if (obs !== 12'h0F0) begin
      fails++; $display("FAIL relock_new_ring: got %h expected 0F0", obs);
    end
    probe(532, 384, 12'h321, obs);
    checks++;
    if (obs !== 12'h321) begin
      fails++; $display("FAIL relock_old_ring: got %h expected 321", obs);
    end
  endtask

  task automatic test_lost_timeout();
    logic [11:0] obs;
    logic [1:0]  exp;
    frame(100, 100, 0);
    checks++;
    if (bus.lock_state !== 2'd2) begin
      fails++; $display("FAIL timeout_enter: got %0d expected 2", bus.lock_state);
    end
    for (int k = 1; k <= 30; k++) begin
      frame(100, 100, 0);
      exp = (k == 30) ? 2'd0 : 2'd2;
      checks++;
      if (bus.lock_state !== exp) begin
        fails++; $display("FAIL timeout_frame[%0d]: got %0d expected %0d", k, bus.lock_state, exp);
      end
    end
    probe(120, 100, 12'h0AB, obs);
    checks++;
    if (obs !== 12'h0AB) begin
      fails++; $display("FAIL timeout_no_draw: got %h expected 0AB", obs);
    end
  endtask

  task automatic test_saturate();
    logic [11:0] obs;
    for (int f = 0; f < 3; f++) frame(5000, 384, 40);
    checks++;
    if (bus.lock_state !== 2'd1) begin
      fails++; $display("FAIL sat_lock: got %0d expected 1", bus.lock_state);
    end
    probe(2007, 384, 12'h111, obs);
    checks++;
    if (obs !== 12'h0F0) begin
      fails++; $display("FAIL sat_ring: got %h expected 0F0", obs);
    end
    for (int c = 0; c <= 100; c++) begin
      probe(c, 384, 12'h2A5, obs);
      checks++;
      if (obs !== 12'h2A5) begin
        fails++; $display("FAIL sat_no_wrap[%0d]: got %h expected 2A5", c, obs);
      end
    end
    // Mid-frame tracker changes must not take effect before the next fall
    @(negedge clk);
    bus.radius   = 24'd2;
    bus.x_center = 32'd100;
    probe(2007, 384, 12'h112, obs);
    checks++;
    if (obs !== 12'h0F0) begin
      fails++; $display("FAIL midframe_hold: got %h expected 0F0", obs);
    end
    checks++;
    if (bus.lock_state !== 2'd1) begin
      fails++; $display("FAIL midframe_state: got %0d expected 1", bus.lock_state);
    end
    frame(100, 384, 2);
    checks++;
    if (bus.lock_state !== 2'd2) begin
      fails++; $display("FAIL midframe_next_state: got %0d expected 2", bus.lock_state);
    end
    probe(2007, 384, 12'h113, obs);
    checks++;
    if (obs !== 12'hF00) begin
      fails++; $display("FAIL midframe_next_ring: got %h expected F00", obs);
    end
  endtask

  task automatic test_crosshair();
    logic [11:0] obs;
    frame(512, 384, 20);
    checks++;
    if (bus.lock_state !== 2'd1) begin
      fails++; $display("FAIL cross_lock: got %0d expected 1", bus.lock_state);
    end
`ifdef TARGET_OVERLAY_CROSSHAIR_EN
    probe(512, 380, 12'h301, obs);
    checks++;
    if (obs !== 12'h0F0) begin
      fails++; $display("FAIL cross_vert: got %h expected 0F0", obs);
    end
    probe(504, 384, 12'h302, obs);
    checks++;
    if (obs !== 12'h0F0) begin
      fails++; $display("FAIL cross_horz: got %h expected 0F0", obs);
    end
`else
    probe(512, 380, 12'h301, obs);
    checks++;
    if (obs !== 12'h301) begin
      fails++; $display("FAIL cross_absent: got %h expected 301", obs);
    end
`endif
    probe(512, 370, 12'h303, obs);
    checks++;
    if (obs !== 12'h303) begin
      fails++; $display("FAIL cross_beyond: got %h expected 303", obs);
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    bus.hcount   = 11'd532;
    bus.vcount   = 10'd384;
    bus.pixel_in = 12'hABC;
    rst_in       = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.lock_state !== 2'd0) begin
      fails++; $display("FAIL rst_mid_state: got %0d expected 0", bus.lock_state);
    end
    @(negedge clk);
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i < 3 && bus.pixel_out !== 12'h000) begin
        fails++; $display("FAIL rst_flush[%0d]: got %h expected 000", i, bus.pixel_out);
      end else if (i == 3 && bus.pixel_out !== 12'hABC) begin
        fails++; $display("FAIL rst_flush[%0d]: got %h expected ABC", i, bus.pixel_out);
      end
      @(posedge clk);
      #1;
    end
    frame(512, 384, 20);
    checks++;
    if (bus.lock_state !== 2'd0) begin
      fails++; $display("FAIL rst_mid_search: got %0d expected 0", bus.lock_state);
    end
  endtask

  initial begin
    checks       = 0;
    fails        = 0;
    rst_in       = 1'b1;
    bus.vsync    = 1'b0;
    bus.hcount   = '0;
    bus.vcount   = '0;
    bus.pixel_in = '0;
    bus.x_center = '0;
    bus.y_center = '0;
    bus.radius   = '0;
    test_reset();
    test_search();
    test_lock();
    test_lost();
    test_lost_timeout();
    test_saturate();
    test_crosshair();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
